// File: rtl/sseg_scan_ctrl.sv
// Two-digit seven-segment scan controller for the mini motor board.
// Generates its own multiplex time base, inserts blanking gaps between the
// digits to avoid ghosting, and overrides both digits with a flashing "E"
// while the over-current alert latch is set.
module sseg_scan_ctrl #(
    parameter int PRESCALE    = 50000,
    parameter int DIGIT_TICKS = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       SW7,
    input  logic       SnsA,
    input  logic       OC_ALERT,
    input  logic       ALERT_ACK,
    output logic [6:0] SSEG_Data,
    output logic       Anode1,
    output logic       Anode2,
    output logic       ASEL,
    output logic       FRAME,
    output logic       ALERT
);

    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TMAX = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PS_LAST    = PW'(PRESCALE - 1);
    localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? TW'(BLANK_TICKS - 1) : '0;
    localparam bit            NO_BLANK   = (BLANK_TICKS == 0);
    localparam logic [6:0]    PAT_E      = 7'b1111001;

    typedef enum logic [2:0] {IDLE, BLANK1, SHOW1, BLANK2, SHOW2} state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   ps_cnt;
    logic [TW-1:0]   tick_cnt;
    logic            sw_meta, sw_sync;
    logic            sns_meta, sns_sync;
    logic            oc_meta, oc_sync;
    logic            alert_q, alert_next;
    logic            flash_q, flash_next;
    logic [6:0]      pat1_q, pat1_d;
    logic [6:0]      pat2_q, pat2_d;
    logic [6:0]      digit1, digit2;
    logic [6:0]      sseg_d;
    logic            an1_d, an2_d, asel_d;
    logic            in_blank, ps_hold, tick;
    logic            blank_done, show_done, frame_evt;
    logic            enter1, enter2;

    // With no blanking ticks the single-cycle BLANK states freeze the
    // prescaler so every digit still receives full-length ticks.
    assign in_blank   = (state == BLANK1) || (state == BLANK2);
    assign ps_hold    = NO_BLANK && in_blank;
    assign tick       = EN && !ps_hold && (ps_cnt == PS_LAST);
    assign blank_done = NO_BLANK || (tick && (tick_cnt == BLANK_LAST));
    assign show_done  = tick && (tick_cnt == DIGIT_LAST);
    assign frame_evt  = (state == SHOW2) && (next_state == BLANK1);

    assign alert_next = oc_sync | (alert_q & ~ALERT_ACK);
    assign ALERT      = alert_q;

    assign digit1 = {3'b000, ~sw_sync, ~sw_sync, 1'b1, sw_sync};
    assign digit2 = {~sns_sync, 1'b1, ~sns_sync, ~sns_sync, ~sns_sync, 1'b1, 1'b1};
    assign enter1 = (next_state == SHOW1) && (state != SHOW1);
    assign enter2 = (next_state == SHOW2) && (state != SHOW2);
    assign pat1_d = enter1 ? (alert_next ? PAT_E : digit1) : pat1_q;
    assign pat2_d = enter2 ? (alert_next ? PAT_E : digit2) : pat2_q;

    // Two-stage synchronizers for the asynchronous board inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_meta  <= 1'b0;
            sw_sync  <= 1'b0;
            sns_meta <= 1'b0;
            sns_sync <= 1'b0;
            oc_meta  <= 1'b0;
            oc_sync  <= 1'b0;
        end else begin
            sw_meta  <= SW7;
            sw_sync  <= sw_meta;
            sns_meta <= SnsA;
            sns_sync <= sns_meta;
            oc_meta  <= OC_ALERT;
            oc_sync  <= oc_meta;
        end
    end

    // Scan prescaler: free-running while enabled, cleared when disabled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps_cnt <= '0;
        end else if (!EN) begin
            ps_cnt <= '0;
        end else if (!ps_hold) begin
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: blank, show digit 1, blank, show digit 2, repeat.
    always_comb begin
        next_state = state;
        if (!EN) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = BLANK1;
                BLANK1:  if (blank_done) next_state = SHOW1;
                SHOW1:   if (show_done)  next_state = BLANK2;
                BLANK2:  if (blank_done) next_state = SHOW2;
                SHOW2:   if (show_done)  next_state = BLANK1;
                default: next_state = IDLE;
            endcase
        end
    end

    // Tick counter restarts on every state change.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_cnt <= '0;
        end else if (next_state != state) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Flash phase toggles once per frame and restarts dark-free from IDLE.
    always_comb begin
        flash_next = flash_q;
        if (next_state == IDLE) begin
            flash_next = 1'b0;
        end else if (frame_evt) begin
            flash_next = ~flash_q;
        end
    end

    // Output decode from the upcoming state so outputs line up with it.
    always_comb begin
        sseg_d = 7'b0;
        an1_d  = 1'b0;
        an2_d  = 1'b0;
        asel_d = 1'b0;
        case (next_state)
            SHOW1: begin
                sseg_d = pat1_d;
                an1_d  = !(alert_next && flash_next);
            end
            BLANK2: begin
                asel_d = 1'b1;
            end
            SHOW2: begin
                sseg_d = pat2_d;
                an2_d  = !(alert_next && flash_next);
                asel_d = 1'b1;
            end
            default: begin
                sseg_d = 7'b0;
            end
        endcase
    end

    // Alert latch, flash phase, captured patterns and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alert_q   <= 1'b0;
            flash_q   <= 1'b0;
            pat1_q    <= 7'b0;
            pat2_q    <= 7'b0;
            SSEG_Data <= 7'b0;
            Anode1    <= 1'b0;
            Anode2    <= 1'b0;
            ASEL      <= 1'b0;
            FRAME     <= 1'b0;
        end else begin
            alert_q   <= alert_next;
            flash_q   <= flash_next;
            pat1_q    <= pat1_d;
            pat2_q    <= pat2_d;
            SSEG_Data <= sseg_d;
            Anode1    <= an1_d;
            Anode2    <= an2_d;
            ASEL      <= asel_d;
            FRAME     <= frame_evt;
        end
    end

endmodule
